cache_l2_assoc: RTL

Parametrised write-back, N-way set-associative L2 cache between the L1 arbiter and physical memory, with a fill port for an external stream prefetcher. It generalises the fixed 2-way L2 to configurable way count and set count. It adds tree pseudo-LRU replacement, allocate-on-write-miss and a shared-bus interlock with the prefetcher. Block size is one lc3b_block (128 bits, 16 bytes); addresses are 16-bit byte addresses.

---
 rtl/cache_l2_assoc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cache_l2_assoc.sv
// cache_l2_assoc: write-back N-way set-associative L2 with tree PLRU, write-allocate
// and a fill port for an external stream prefetcher sharing the pmem bus.
module cache_l2_assoc #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    input  logic         prefetch_ready,
    input  logic         prefetch_busy,
    input  logic [127:0] prefetch_rdata,
    input  logic [15:0]  prefetch_address,
    output logic         dont_prefetch
);
    localparam int IDX = $clog2(SETS);
    localparam int WB  = $clog2(WAYS);
    localparam int TW  = 12 - IDX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e          state_q, state_d;
    logic [WB-1:0]   victim_q, victim_d;
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [127:0]    data_q  [SETS][WAYS];

    logic [IDX-1:0]  idx, p_idx;
    logic [TW-1:0]   tag, p_tag;
    logic [WB-1:0]   hit_way, miss_way, p_way;
    logic            req, hit, p_hit, p_ok, fill_done;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a set bit steers toward the right half.
    function automatic logic [WB-1:0] pick_victim(input logic [WAYS-1:0] v, input logic [WAYS-2:0] p);
        logic [WB:0] n;
        n = '0;
        for (int l = 0; l < WB; l++) n = {n[WB-1:0], 1'b1} + {{WB{1'b0}}, p[n[WB-1:0]]};
        pick_victim = WB'(n - (WB+1)'(WAYS - 1));
        for (int w = WAYS - 1; w >= 0; w--) if (!v[w]) pick_victim = WB'(w);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p, input logic [WB-1:0] w);
        logic [WB:0]   n;
        logic [WB-1:0] s;
        plru_touch = p;
        n = '0;
        s = w;
        for (int l = 0; l < WB; l++) begin
            plru_touch[n[WB-1:0]] = ~s[WB-1];
            n = {n[WB-1:0], 1'b1} + {{WB{1'b0}}, s[WB-1]};
            s = s << 1;
        end
    endfunction

    always_comb begin
        idx   = mem_address[4 +: IDX];
        tag   = mem_address[15 -: TW];
        p_idx = prefetch_address[4 +: IDX];
        p_tag = prefetch_address[15 -: TW];
        hit     = 1'b0;
        hit_way = '0;
        p_hit   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (valid_q[p_idx][w] && tag_q[p_idx][w] == p_tag) p_hit = 1'b1;
        end
        miss_way      = pick_victim(valid_q[idx], plru_q[idx]);
        p_way         = pick_victim(valid_q[p_idx], plru_q[p_idx]);
        req           = mem_read | mem_write;
        mem_resp      = (state_q == IDLE) && req && hit;
        mem_rdata     = mem_resp ? data_q[idx][hit_way] : '0;
        pmem_write    = state_q == WRITEBACK;
        pmem_read     = state_q == FILL;
        pmem_address  = pmem_write ? {tag_q[idx][victim_q], idx, 4'h0} :
                        pmem_read  ? {mem_address[15:4], 4'h0} : '0;
        pmem_wdata    = pmem_write ? data_q[idx][victim_q] : '0;
        dont_prefetch = (state_q != IDLE) || req;
        p_ok          = prefetch_ready && !dont_prefetch && !p_hit &&
                        !(valid_q[p_idx][p_way] && dirty_q[p_idx][p_way]);
        fill_done     = (state_q == FILL) && pmem_resp;
        state_d  = state_q;
        victim_d = victim_q;
        if (state_q == IDLE && req && !hit && !prefetch_busy) begin
            victim_d = miss_way;
            state_d  = (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) ? WRITEBACK : FILL;
        end else if (state_q == WRITEBACK && pmem_resp) begin
            state_d = FILL;
        end else if (fill_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (mem_resp) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            // Prefetched lines leave PLRU untouched so they are evicted first if unused.
            if (p_ok) begin
                valid_q[p_idx][p_way] <= 1'b1;
                dirty_q[p_idx][p_way] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_resp && mem_write) data_q[idx][hit_way] <= mem_wdata;
        if (fill_done) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
        if (p_ok) begin
            data_q[p_idx][p_way] <= prefetch_rdata;
            tag_q[p_idx][p_way]  <= p_tag;
        end
    end
endmodule
